// File: rtl/acs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acs_pkg
// Purpose  : Shared types, constants and trellis helpers for the ACS scheduler
//            of a 4-state, K=3, rate-1/2 Viterbi decoder (g0=7, g1=5).
// Contents : W_DEF / INIT_PEN_DEF defaults, NS, FSM state enum,
//            predecessor functions p0/p1 and branch-metric index bm_idx.
// Revision : 1.0 - initial release
// ============================================================================
package acs_pkg;

    localparam int W_DEF        = 6;   // metric width, matches the shared adder
    localparam int INIT_PEN_DEF = 16;  // starting metric of states 1..3
    localparam int NS           = 4;   // number of trellis states

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD0 = 2'd1,
        ADD1 = 2'd2,
        DONE = 2'd3
    } acs_state_t;

    // Next state ns = {u, x}; both predecessors share s1 = x and differ in s0.
    function automatic logic [1:0] p0(input logic [1:0] ns);
        return {ns[0], 1'b0};
    endfunction

    function automatic logic [1:0] p1(input logic [1:0] ns);
        return {ns[0], 1'b1};
    endfunction

    // Codeword emitted on pred -> ns with input bit u = ns[1]:
    //   c0 = u ^ s1 ^ s0 (g0=111), c1 = u ^ s0 (g1=101); index = {c0, c1}.
    function automatic logic [1:0] bm_idx(input logic [1:0] pred, input logic [1:0] ns);
        logic c0;
        logic c1;
        c0 = ns[1] ^ pred[1] ^ pred[0];
        c1 = ns[1] ^ pred[0];
        return {c0, c1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/acs_min4.sv
`default_nettype none
// ============================================================================
// Module   : acs_min4
// Purpose  : Combinational 4-way signed minimum; reports the index of the
//            smallest metric, lowest index on a tie.
// Ports    : pm   in  NS*W  metrics, slice s = state s
//            best out 2     index of the minimum
// Revision : 1.0 - initial release
// ============================================================================
module acs_min4
    import acs_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [NS*W-1:0] pm,
    output logic [1:0]      best
);

    logic signed [W-1:0] w_v [NS];

    for (genvar gi = 0; gi < NS; gi++) begin : g_unpack
        assign w_v[gi] = pm[gi*W +: W];
    end

    logic                w_lo_sel;
    logic                w_hi_sel;
    logic signed [W-1:0] w_lo_min;
    logic signed [W-1:0] w_hi_min;

    // Strict less-than at every level keeps the lower index on ties.
    assign w_lo_sel = (w_v[1] < w_v[0]);
    assign w_hi_sel = (w_v[3] < w_v[2]);
    assign w_lo_min = w_lo_sel ? w_v[1] : w_v[0];
    assign w_hi_min = w_hi_sel ? w_v[3] : w_v[2];

    assign best = (w_hi_min < w_lo_min) ? {1'b1, w_hi_sel} : {1'b0, w_lo_sel};

endmodule
`default_nettype wire

// File: rtl/acs_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : acs_scheduler
// Purpose  : Time-multiplexes one external 6-bit signed saturating adder over
//            the 8 add-compare-select operations of a 4-state Viterbi trellis
//            step, then commits the survivor metrics in one edge.
// Ports    : clk        in   rising-edge clock
//            rst_n      in   synchronous reset, active low
//            init       in   reload initial metrics (IDLE only, beats step_valid)
//            step_valid in   bm_in holds a valid trellis step
//            step_ready out  idle, accepts a step
//            bm_in      in   4*W branch metrics, slice k = codeword {c0,c1}=k
//            add_a      out  W shared adder operand a (path metric)
//            add_b      out  W shared adder operand b (branch metric)
//            add_y      in   W shared adder saturated sum, same cycle
//            surv_valid out  one-cycle strobe for surv_bits/best_state/pm_out
//            surv_bits  out  4 survivor decision per next state (1 = pred p1)
//            best_state out  2 index of minimum new metric
//            pm_out     out  4*W current path metrics, slice s = state s
//            sat_flag   out  sticky: a selected metric reached +2^(W-1)-1
// Revision : 1.0 - initial release
// ============================================================================
module acs_scheduler
    import acs_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int INIT_PEN = INIT_PEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init,
    input  logic            step_valid,
    output logic            step_ready,
    input  logic [NS*W-1:0] bm_in,
    output logic [W-1:0]    add_a,
    output logic [W-1:0]    add_b,
    input  logic [W-1:0]    add_y,
    output logic            surv_valid,
    output logic [3:0]      surv_bits,
    output logic [1:0]      best_state,
    output logic [NS*W-1:0] pm_out,
    output logic            sat_flag
);

    localparam logic [NS*W-1:0] c_pm_init = {{3{W'(INIT_PEN)}}, {W{1'b0}}};
    localparam logic [W-1:0]    c_sat_max = {1'b0, {(W-1){1'b1}}};

    acs_state_t      r_state;
    acs_state_t      w_state_nxt;
    logic [1:0]      r_ns;
    logic [NS*W-1:0] r_bm;
    logic [NS*W-1:0] r_pm;
    logic [NS*W-1:0] r_pm_nxt;
    logic [W-1:0]    r_cand0;
    logic [3:0]      r_surv_nxt;
    logic [3:0]      r_surv_bits;
    logic [1:0]      r_best;
    logic            r_sat;

    logic            w_in_add;
    logic            w_accept;
    logic [1:0]      w_pred;
    logic [1:0]      w_idx;
    logic            w_take_p1;
    logic [W-1:0]    w_winner;
    logic [NS*W-1:0] w_pm_nxt_d;
    logic [3:0]      w_surv_d;
    logic [1:0]      w_best;

    // ------------------------------------------------------------------
    // FSM: state register and next-state / control outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        step_ready  = 1'b0;
        surv_valid  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                step_ready = 1'b1;
                // init takes priority; the step stays pending upstream.
                w_accept = step_valid && !init;
                if (w_accept) w_state_nxt = ADD0;
            end
            ADD0: w_state_nxt = ADD1;
            ADD1: w_state_nxt = (r_ns == 2'd3) ? DONE : ADD0;
            DONE: begin
                surv_valid  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Adder operand steering: ADD0 reads predecessor p0, ADD1 reads p1.
    // Reads always come from the committed metrics, never from pm_nxt.
    // ------------------------------------------------------------------
    assign w_in_add = (r_state == ADD0) || (r_state == ADD1);
    assign w_pred   = (r_state == ADD1) ? p1(r_ns) : p0(r_ns);
    assign w_idx    = bm_idx(w_pred, r_ns);
    assign add_a    = w_in_add ? r_pm[w_pred*W +: W] : '0;
    assign add_b    = w_in_add ? r_bm[w_idx*W +: W]  : '0;

    // p1 wins only when strictly smaller; ties keep p0.
    assign w_take_p1 = $signed(add_y) < $signed(r_cand0);
    assign w_winner  = w_take_p1 ? add_y : r_cand0;

    // Next value of the shadow metrics/decisions, including the write of
    // the current ADD1 cycle, so the last write can commit in the same edge.
    always_comb begin
        w_pm_nxt_d = r_pm_nxt;
        w_surv_d   = r_surv_nxt;
        if (r_state == ADD1) begin
            w_pm_nxt_d[r_ns*W +: W] = w_winner;
            w_surv_d[r_ns]          = w_take_p1;
        end
    end

    acs_min4 #(
        .W (W)
    ) u_min4 (
        .pm   (w_pm_nxt_d),
        .best (w_best)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ns        <= 2'd0;
            r_bm        <= '0;
            r_pm        <= c_pm_init;
            r_pm_nxt    <= '0;
            r_cand0     <= '0;
            r_surv_nxt  <= 4'd0;
            r_surv_bits <= 4'd0;
            r_best      <= 2'd0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (init) begin
                        r_pm <= c_pm_init;
                    end else if (w_accept) begin
                        r_bm <= bm_in;
                        r_ns <= 2'd0;
                    end
                end
                ADD0: r_cand0 <= add_y;
                ADD1: begin
                    r_pm_nxt   <= w_pm_nxt_d;
                    r_surv_nxt <= w_surv_d;
                    if (w_winner == c_sat_max) r_sat <= 1'b1;
                    if (r_ns == 2'd3) begin
                        // Entry edge of DONE: commit the whole step at once.
                        r_pm        <= w_pm_nxt_d;
                        r_surv_bits <= w_surv_d;
                        r_best      <= w_best;
                    end else begin
                        r_ns <= r_ns + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pm_out     = r_pm;
    assign surv_bits  = r_surv_bits;
    assign best_state = r_best;
    assign sat_flag   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_acs_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_acs_scheduler
// Purpose  : Directed-vector bench for acs_scheduler with a behavioural
//            saturating adder on the shared-adder port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acs_scheduler;

    localparam int W = 6;

    logic           clk;
    logic           rst_n;
    logic           init;
    logic           step_valid;
    logic           step_ready;
    logic [4*W-1:0] bm_in;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_y;
    logic           surv_valid;
    logic [3:0]     surv_bits;
    logic [1:0]     best_state;
    logic [4*W-1:0] pm_out;
    logic           sat_flag;

    int n_vec = 0;
    int n_err = 0;

    acs_scheduler #(
        .W        (6),
        .INIT_PEN (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .bm_in      (bm_in),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_y      (add_y),
        .surv_valid (surv_valid),
        .surv_bits  (surv_bits),
        .best_state (best_state),
        .pm_out     (pm_out),
        .sat_flag   (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shared adder: signed, saturating to [-32, 31].
    logic signed [W:0] w_sum;
    always_comb begin
        w_sum = {add_a[W-1], add_a} + {add_b[W-1], add_b};
        if (w_sum[W] != w_sum[W-1]) add_y = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else                        add_y = w_sum[W-1:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pack four metrics, state 3 first.
    function automatic logic [4*W-1:0] pk(input int s3, input int s2, input int s1, input int s0);
        return {6'(s3), 6'(s2), 6'(s1), 6'(s0)};
    endfunction

    // Called just after a negedge with the DUT idle; returns at the negedge
    // of the surv_valid cycle (cycle 9 when timing is right).
    task automatic run_step(input logic [4*W-1:0] bm, input string tag);
        int lat;
        bm_in      = bm;
        step_valid = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        lat = 1;
        while (!surv_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 9);
    endtask

    localparam logic [4*W-1:0] c_pm_init = {6'd16, 6'd16, 6'd16, 6'd0};

    initial begin
        int pulses;
        int busy_ready;
        rst_n      = 1'b0;
        init       = 1'b0;
        step_valid = 1'b0;
        bm_in      = '0;

        // ---- reset ----
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", step_ready, 1);
        chk("rst_sv", surv_valid, 0);
        chk("rst_pm", pm_out, c_pm_init);
        chk("rst_sat", sat_flag, 0);
        chk("rst_adda", add_a, 0);
        chk("rst_surv", surv_bits, 0);
        chk("rst_best", best_state, 0);
        rst_n = 1'b1;

        // ---- basic step with cycle-level checks ----
        bm_in      = pk(2, 1, 1, 0);
        step_valid = 1'b1;
        @(negedge clk);                 // cycle 1
        step_valid = 1'b0;
        chk("c1_adda", add_a, 0);
        chk("c1_addb", add_b, 0);
        chk("c1_ready", step_ready, 0);
        @(negedge clk);                 // cycle 2
        chk("c2_adda", add_a, 16);
        chk("c2_addb", add_b, 2);
        repeat (7) @(negedge clk);      // cycle 9
        chk("c9_sv", surv_valid, 1);
        chk("c9_pm", pm_out, pk(17, 2, 17, 0));
        chk("c9_surv", surv_bits, 4'b0000);
        chk("c9_best", best_state, 0);
        @(negedge clk);                 // cycle 10
        chk("c10_sv", surv_valid, 0);
        chk("c10_ready", step_ready, 1);
        chk("c10_adda", add_a, 0);

        // ---- handshake: step_valid held across two steps ----
        bm_in      = pk(2, 1, 1, 0);
        step_valid = 1'b1;
        pulses     = 0;
        busy_ready = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 11) step_valid = 1'b0;
            if (c <= 9 && step_ready) busy_ready++;
            if (c == 10) chk("hs_c10_ready", step_ready, 1);
            if (surv_valid) pulses++;
        end
        chk("hs_busy_ready", busy_ready, 0);
        chk("hs_pulses", pulses, 2);
        chk("hs_pm", pm_out, pk(3, 2, 3, 0));

        // ---- init and step_valid together: init wins ----
        init       = 1'b1;
        step_valid = 1'b1;
        @(negedge clk);
        init       = 1'b0;
        step_valid = 1'b0;
        chk("init_ready", step_ready, 1);
        chk("init_pm", pm_out, c_pm_init);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (surv_valid) pulses++;
        end
        chk("init_noacc", pulses, 0);

        // ---- p1 selection; unselected path saturates ----
        run_step(pk(0, 0, 0, 20), "p1");
        chk("p1_surv", surv_bits, 4'b0001);
        chk("p1_pm", pm_out, pk(16, 0, 16, 16));
        chk("p1_best", best_state, 2);
        chk("p1_sat", sat_flag, 0);
        @(negedge clk);

        // ---- negative metrics: signed compare and signed minimum ----
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        run_step(pk(0, 0, 0, -10), "neg");
        chk("neg_pm", pm_out, pk(16, 0, 16, -10));
        chk("neg_surv", surv_bits, 4'b0000);
        chk("neg_best", best_state, 0);
        @(negedge clk);
        chk("hold_surv", surv_bits, 4'b0000);
        chk("hold_best", best_state, 0);

        // ---- saturation, three steps, sticky flag ----
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        run_step(pk(31, 31, 31, 31), "sat1");
        chk("sat1_pm", pm_out, pk(31, 31, 31, 31));
        chk("sat1_flag", sat_flag, 1);
        @(negedge clk);
        run_step(pk(31, 31, 31, 31), "sat2");
        @(negedge clk);
        run_step(pk(31, 31, 31, 31), "sat3");
        chk("sat3_pm", pm_out, pk(31, 31, 31, 31));
        chk("sat3_best", best_state, 0);
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        chk("sat_sticky", sat_flag, 1);

        // ---- reset in the middle of a step ----
        run_step(pk(2, 1, 1, 0), "pre");
        chk("pre_pm", pm_out, pk(17, 2, 17, 0));
        @(negedge clk);
        bm_in      = pk(0, 0, 0, 20);
        step_valid = 1'b1;
        @(negedge clk);                 // cycle 1
        step_valid = 1'b0;
        repeat (4) @(negedge clk);      // cycle 5
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_ready", step_ready, 1);
        chk("mid_pm", pm_out, c_pm_init);
        chk("mid_sat", sat_flag, 0);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (surv_valid) pulses++;
        end
        chk("mid_nosv", pulses, 0);
        chk("mid_pm2", pm_out, c_pm_init);

        // ---- init after a step restores initial metrics ----
        run_step(pk(2, 1, 1, 0), "post");
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        chk("post_init_pm", pm_out, c_pm_init);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
